// File: rtl/rib_uart_pkg.sv
// rtl/rib_uart_pkg.sv - register offsets, STATUS bit indices and FSM encodings for rib_uart_slave
package rib_uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_BAUD   = 2'd2;

  localparam int ST_TX_FULL    = 0;
  localparam int ST_TX_EMPTY   = 1;
  localparam int ST_RX_VALID   = 2;
  localparam int ST_RX_OVERRUN = 3;

  localparam logic [15:0] DIV_MIN = 16'd4;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  function automatic logic [15:0] clamp_div(input logic [15:0] d);
    return (d < DIV_MIN) ? DIV_MIN : d;
  endfunction

endpackage

// File: rtl/rib_uart_fifo.sv
// rtl/rib_uart_fifo.sv - synchronous byte FIFO for the UART transmit queue
module rib_uart_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] pop_data,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        do_push, do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  // a push into a full FIFO is accepted when the same cycle frees a slot
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/rib_uart_slave.sv
// rtl/rib_uart_slave.sv - RIB-bus slave UART: TX FIFO + 8N1 serialiser, RX deserialiser, DATA/STATUS/BAUD_DIV
module rib_uart_slave
  import rib_uart_pkg::*;
#(
  parameter int          TX_DEPTH      = 8,
  parameter logic [15:0] DIV_RESET     = 16'd868,
  parameter int          ADDR_LSB_USED = 4
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [31:0] i_ribs_addr,
  input  logic        i_ribs_wrcs,
  input  logic [3:0]  i_ribs_mask,
  input  logic [31:0] i_ribs_wdata,
  output logic [31:0] o_ribs_rdata,
  input  logic        i_ribs_req,
  output logic        o_ribs_gnt,
  output logic        o_ribs_rsp,
  input  logic        i_ribs_rdy,
  input  logic        i_io_rx,
  output logic        o_io_tx
);
  logic [1:0]  reg_sel;
  logic        accept, wr_acc, data_read, unused;
  logic        rsp_pending, rx_valid, rx_overrun;
  logic [31:0] rdata_q, rd_val;
  logic [15:0] baud_div, baud_wr;
  logic [7:0]  rx_byte, fifo_dout;
  logic [3:0]  status;
  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;

  tx_state_t   tx_state, tx_state_d;
  logic [15:0] tx_cnt, tx_cnt_d, tx_div, tx_div_d;
  logic [2:0]  tx_bit, tx_bit_d;
  logic [7:0]  tx_shift, tx_shift_d;
  logic        tx_line_d;

  rx_state_t   rx_state, rx_state_d;
  logic [15:0] rx_cnt, rx_cnt_d, rx_div, rx_div_d;
  logic [2:0]  rx_bit, rx_bit_d;
  logic [7:0]  rx_shift, rx_shift_d;
  logic        rx_meta, rx_sync, rx_prev, rx_land;

  assign reg_sel   = i_ribs_addr[ADDR_LSB_USED-1:2];
  assign unused    = ^{i_ribs_addr[31:ADDR_LSB_USED], i_ribs_addr[1:0], i_ribs_wdata[31:16], i_ribs_mask[3:2]};
  assign o_ribs_gnt   = !rsp_pending;
  assign o_ribs_rsp   = rsp_pending;
  assign o_ribs_rdata = rdata_q;
  assign accept    = i_ribs_req && !rsp_pending;
  assign wr_acc    = accept && i_ribs_wrcs;
  assign data_read = accept && !i_ribs_wrcs && (reg_sel == REG_DATA);
  assign fifo_push = wr_acc && (reg_sel == REG_DATA) && i_ribs_mask[0];
  assign baud_wr   = {i_ribs_mask[1] ? i_ribs_wdata[15:8] : baud_div[15:8],
                      i_ribs_mask[0] ? i_ribs_wdata[7:0]  : baud_div[7:0]};

  assign status[ST_TX_FULL]    = fifo_full;
  assign status[ST_TX_EMPTY]   = fifo_empty && (tx_state == TX_IDLE);
  assign status[ST_RX_VALID]   = rx_valid;
  assign status[ST_RX_OVERRUN] = rx_overrun;

  always_comb begin
    rd_val = '0;
    case (reg_sel)
      REG_DATA:   rd_val[7:0]  = rx_valid ? rx_byte : 8'h00;
      REG_STATUS: rd_val[3:0]  = status;
      REG_BAUD:   rd_val[15:0] = baud_div;
      default:    rd_val       = '0;
    endcase
  end

  rib_uart_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(i_clk), .rstn(i_rstn), .push(fifo_push), .push_data(i_ribs_wdata[7:0]),
    .pop(fifo_pop), .pop_data(fifo_dout), .full(fifo_full), .empty(fifo_empty)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rsp_pending <= 1'b0;
      rdata_q     <= '0;
      baud_div    <= DIV_RESET;
      rx_valid    <= 1'b0;
      rx_byte     <= '0;
      rx_overrun  <= 1'b0;
    end else begin
      if (accept) begin
        rsp_pending <= 1'b1;
        rdata_q     <= i_ribs_wrcs ? 32'h0 : rd_val;
      end else if (rsp_pending && i_ribs_rdy) begin
        rsp_pending <= 1'b0;
        rdata_q     <= '0;
      end
      if (wr_acc && (reg_sel == REG_BAUD) && (|i_ribs_mask[1:0]))
        baud_div <= clamp_div(baud_wr);
      if (wr_acc && (reg_sel == REG_STATUS) && i_ribs_wdata[ST_RX_OVERRUN])
        rx_overrun <= 1'b0;
      // a byte landing alongside a DATA read hands the old byte to the reader, so no overrun
      if (rx_land) begin
        rx_byte  <= rx_shift;
        rx_valid <= 1'b1;
        if (rx_valid && !data_read) rx_overrun <= 1'b1;
      end else if (data_read) begin
        rx_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_div   <= DIV_RESET;
      tx_bit   <= '0;
      tx_shift <= '0;
      o_io_tx  <= 1'b1;
    end else begin
      tx_state <= tx_state_d;
      tx_cnt   <= tx_cnt_d;
      tx_div   <= tx_div_d;
      tx_bit   <= tx_bit_d;
      tx_shift <= tx_shift_d;
      o_io_tx  <= tx_line_d;
    end
  end

  // divisor is latched per frame so BAUD_DIV writes never disturb a frame in flight
  always_comb begin
    tx_state_d = tx_state;
    tx_cnt_d   = tx_cnt + 16'd1;
    tx_div_d   = tx_div;
    tx_bit_d   = tx_bit;
    tx_shift_d = tx_shift;
    fifo_pop   = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        tx_cnt_d = '0;
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          tx_shift_d = fifo_dout;
          tx_div_d   = baud_div;
          tx_state_d = TX_START;
        end
      end
      TX_START: if (tx_cnt == tx_div - 16'd1) begin
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        tx_state_d = TX_DATA;
      end
      TX_DATA: if (tx_cnt == tx_div - 16'd1) begin
        tx_cnt_d   = '0;
        tx_shift_d = {1'b0, tx_shift[7:1]};
        tx_bit_d   = tx_bit + 3'd1;
        if (tx_bit == 3'd7) tx_state_d = TX_STOP;
      end
      TX_STOP: if (tx_cnt == tx_div - 16'd1) begin
        tx_cnt_d = '0;
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          tx_shift_d = fifo_dout;
          tx_div_d   = baud_div;
          tx_state_d = TX_START;
        end else begin
          tx_state_d = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    tx_line_d = (tx_state_d == TX_START) ? 1'b0 :
                (tx_state_d == TX_DATA)  ? tx_shift_d[0] : 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_div   <= DIV_RESET;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_meta  <= i_io_rx;
      rx_sync  <= rx_meta;
      rx_prev  <= rx_sync;
      rx_state <= rx_state_d;
      rx_cnt   <= rx_cnt_d;
      rx_div   <= rx_div_d;
      rx_bit   <= rx_bit_d;
      rx_shift <= rx_shift_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state;
    rx_cnt_d   = rx_cnt + 16'd1;
    rx_div_d   = rx_div;
    rx_bit_d   = rx_bit;
    rx_shift_d = rx_shift;
    rx_land    = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev && !rx_sync) begin
          rx_div_d   = baud_div;
          rx_state_d = RX_START;
        end
      end
      // mid-start check rejects glitches shorter than half a bit
      RX_START: if (rx_cnt == {1'b0, rx_div[15:1]} - 16'd1) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_sync ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt == rx_div - 16'd1) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_sync, rx_shift[7:1]};
        rx_bit_d   = rx_bit + 3'd1;
        if (rx_bit == 3'd7) rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_cnt == rx_div - 16'd1) begin
        rx_cnt_d   = '0;
        rx_land    = rx_sync;
        rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

endmodule

// File: tb/tb_rib_uart_slave.sv
// tb/tb_rib_uart_slave.sv - directed self-checking bench for rib_uart_slave
module tb_rib_uart_slave;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] addr = '0;
  logic        wrcs = 1'b0;
  logic [3:0]  mask = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        req = 1'b0;
  logic        gnt, rsp;
  logic        rdy = 1'b1;
  logic        rx = 1'b1;
  logic        tx;

  int checks = 0;
  int passed = 0;

  logic tx_log [0:4095];
  int   log_n = 0;
  logic log_en = 1'b0;

  rib_uart_slave #(.TX_DEPTH(8), .DIV_RESET(16'd868), .ADDR_LSB_USED(4)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_ribs_addr(addr), .i_ribs_wrcs(wrcs),
    .i_ribs_mask(mask), .i_ribs_wdata(wdata), .o_ribs_rdata(rdata),
    .i_ribs_req(req), .o_ribs_gnt(gnt), .o_ribs_rsp(rsp), .i_ribs_rdy(rdy),
    .i_io_rx(rx), .o_io_tx(tx)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!log_en) log_n <= 0;
    else begin
      if (log_n < 4096) tx_log[log_n] <= tx;
      log_n <= log_n + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic bus(input logic [31:0] a, input logic wr, input logic [3:0] m,
                     input logic [31:0] wd, output logic [31:0] rd);
    @(negedge clk);
    addr = a; wrcs = wr; mask = m; wdata = wd; req = 1'b1; rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    chk("rsp_next_cycle", {63'b0, rsp}, 64'd1);
    rd = rdata;
    @(posedge clk);
  endtask

  task automatic wr_reg(input logic [31:0] a, input logic [3:0] m, input logic [31:0] wd);
    logic [31:0] rd;
    bus(a, 1'b1, m, wd, rd);
    chk("write_rdata", {32'b0, rd}, 64'd0);
  endtask

  task automatic rd_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    bus(a, 1'b0, 4'hF, 32'h0, rd);
    chk(tag, {32'b0, rd}, {32'b0, exp});
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop_bit, input int div);
    @(negedge clk);
    rx = 1'b0;
    repeat (div) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      rx = b[k];
      repeat (div) @(negedge clk);
    end
    rx = stop_bit;
    repeat (div) @(negedge clk);
    rx = 1'b1;
    repeat (div) @(negedge clk);
  endtask

  function automatic int find_low(input int from);
    for (int i = from; i < log_n && i < 4096; i++)
      if (tx_log[i] === 1'b0) return i;
    return -1;
  endfunction

  // samples of one frame at BAUD_DIV=4, bit i of the result is sample i
  function automatic logic [39:0] frame_obs(input int base);
    logic [39:0] o;
    if (base < 0 || base + 39 >= 4096) return 40'bx;
    for (int i = 0; i < 40; i++) o[i] = tx_log[base + i];
    return o;
  endfunction

  function automatic logic [39:0] frame_exp(input logic [7:0] b);
    logic [39:0] e;
    for (int i = 0; i < 40; i++) begin
      if (i < 4)       e[i] = 1'b0;
      else if (i < 36) e[i] = b[(i - 4) / 4];
      else             e[i] = 1'b1;
    end
    return e;
  endfunction

  logic [7:0] burst [10] = '{8'hA5, 8'h5A, 8'h00, 8'hFF, 8'h81, 8'h42, 8'h18, 8'hC3, 8'h7E, 8'h99};
  int s;

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_rsp",   {63'b0, rsp}, 64'd0);
    chk("reset_gnt",   {63'b0, gnt}, 64'd1);
    chk("reset_rdata", {32'b0, rdata}, 64'd0);
    chk("reset_tx",    {63'b0, tx}, 64'd1);
    rstn = 1'b1;

    rd_reg("reset_baud",   32'h8, 32'd868);
    rd_reg("reset_status", 32'h4, 32'h2);
    rd_reg("empty_data",   32'h0, 32'h0);
    rd_reg("reserved_rd",  32'hC, 32'h0);
    wr_reg(32'h8, 4'h3, 32'd2);
    rd_reg("baud_clamp",   32'h8, 32'd4);
    wr_reg(32'h18, 4'h3, 32'd4);
    rd_reg("baud_alias",   32'h8, 32'd4);

    log_en = 1'b1;
    wr_reg(32'h0, 4'h1, 32'h55);
    repeat (50) @(negedge clk);
    s = find_low(0);
    chk("t1_start_latency", s, 2);
    chk("t1_frame", frame_obs(s), frame_exp(8'h55));
    chk("t1_idle_after", {63'b0, tx_log[s + 40]}, 64'd1);
    log_en = 1'b0;
    rd_reg("t1_status", 32'h4, 32'h2);

    @(negedge clk);
    log_en = 1'b1;
    for (int k = 0; k < 10; k++) wr_reg(32'h0, 4'h1, {24'b0, burst[k]});
    rd_reg("t2_status_full", 32'h4, 32'h1);
    repeat (400) @(negedge clk);
    s = find_low(0);
    for (int f = 0; f < 9; f++)
      chk($sformatf("t2_frame%0d", f), frame_obs(s + 40 * f), frame_exp(burst[f]));
    chk("t2_dropped_byte", find_low(s + 360), -1);
    log_en = 1'b0;
    rd_reg("t2_status_done", 32'h4, 32'h2);

    @(negedge clk);
    addr = 32'h8; wrcs = 1'b0; mask = 4'hF; req = 1'b1; rdy = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t3_hold%0d", i), {29'b0, rsp, gnt, rdata}, {29'b0, 1'b1, 1'b0, 32'd4});
      @(negedge clk);
    end
    rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t3_release", {62'b0, rsp, gnt}, 64'b01);

    wr_reg(32'h8, 4'h3, 32'd8);
    rx_frame(8'hA3, 1'b1, 8);
    rd_reg("t4_status_valid", 32'h4, 32'h6);
    rd_reg("t4_data",         32'h0, 32'hA3);
    rd_reg("t4_status_clear", 32'h4, 32'h2);
    @(negedge clk);
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    rd_reg("t4_glitch", 32'h4, 32'h2);
    rx_frame(8'h5C, 1'b0, 8);
    repeat (10) @(negedge clk);
    rd_reg("t4_framing", 32'h4, 32'h2);

    rx_frame(8'h11, 1'b1, 8);
    rx_frame(8'h22, 1'b1, 8);
    rd_reg("t5_overrun", 32'h4, 32'hE);
    wr_reg(32'h4, 4'hF, 32'h8);
    rd_reg("t5_ovr_clear", 32'h4, 32'h6);
    rd_reg("t5_data",      32'h0, 32'h22);
    rd_reg("t5_status",    32'h4, 32'h2);

    wr_reg(32'h8, 4'h3, 32'd4);
    wr_reg(32'h0, 4'h1, 32'h00);
    wr_reg(32'h0, 4'h1, 32'h0F);
    repeat (6) @(negedge clk);
    chk("t6_tx_low", {63'b0, tx}, 64'd0);
    rstn = 1'b0;
    #1;
    chk("t6_tx_async", {63'b0, tx}, 64'd1);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    log_en = 1'b1;
    rd_reg("t6_status", 32'h4, 32'h2);
    rd_reg("t6_baud",   32'h8, 32'd868);
    repeat (60) @(negedge clk);
    chk("t6_fifo_flushed", find_low(0), -1);
    log_en = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
